pwm_multi_channel: RTL

Parametrised multi-channel PWM generator and successor to the single-channel 8-bit pwm_generator. It drives CHANNELS outputs from one shared period counter, with a programmable period, per-channel duty, and edge- or center-aligned mode. Period, duty and mode pass through shadow registers that update only at a period boundary, so outputs never glitch mid-period. It sits beside the motor/LED drive logic and is configured from a register block.

---
 rtl/pwm_multi_channel_if.sv | 15 +
 rtl/pwm_multi_channel.sv | 61 ++++++
 2 files changed

// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: configuration inputs and PWM outputs of pwm_multi_channel.
//   en/center/period/duty flow master -> slave; pwm_out/period_end flow slave -> master.
interface pwm_multi_channel_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      en;
  logic                      center;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_end;
  modport master (output en, center, period, duty, input pwm_out, period_end);
  modport slave (input en, center, period, duty, output pwm_out, period_end);
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: CHANNELS PWM outputs from one shared counter, edge/center aligned.
//   clk: rising-edge clock; rst: asynchronous active-low reset
//   bus.en/center/period/duty: configuration, shadowed at each period boundary
//   bus.pwm_out: registered outputs; bus.period_end: high in the last cycle of a period
module pwm_multi_channel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input logic              clk,
  input logic              rst,
  pwm_multi_channel_if.slave bus
);
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  logic [WIDTH-1:0]          cnt_q, cnt_d, p_q;
  logic                      dir_q, dir_d, mode_q;
  logic [CHANNELS*WIDTH-1:0] d_q;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      run, top, bottom, load;
  assign run    = bus.en && (p_q != '0);
  assign top    = cnt_q == p_q - WIDTH'(1);
  assign bottom = cnt_q == '0;
  // A zero period reports a boundary every cycle so a new period loads at once.
  assign bus.period_end = rst && bus.en &&
                          ((p_q == '0) || (mode_q ? (dir_q == DIR_DN && bottom) : top));
  assign load = bus.period_end || !bus.en;
  // Center mode holds the counter for one extra cycle at both ends while dir flips.
  always_comb begin
    cnt_d = '0;
    dir_d = DIR_UP;
    if (run && mode_q) begin
      dir_d = (dir_q == DIR_UP) ? (top ? DIR_DN : DIR_UP) : (bottom ? DIR_UP : DIR_DN);
      cnt_d = (dir_q == DIR_UP) ? (top ? cnt_q : cnt_q + WIDTH'(1))
                                : (bottom ? cnt_q : cnt_q - WIDTH'(1));
    end else if (run)
      cnt_d = top ? '0 : cnt_q + WIDTH'(1);
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
    assign pwm_d[c] = run && (cnt_q < d_q[c*WIDTH +: WIDTH]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      p_q    <= '0;
      d_q    <= '0;
      mode_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      pwm_q <= pwm_d;
      if (load) begin
        p_q    <= bus.period;
        d_q    <= bus.duty;
        mode_q <= bus.center;
      end
    end
  end
  assign bus.pwm_out = pwm_q;
endmodule
